kb_num_entry: RTL
=================

// Module: kb_num_entry
// PURPOSE
//  Upstream operand-entry stage of the keyboard calculator datapath.
//  Accumulates decoded decimal key presses into a binary operand (value = value*10 + digit)
//    and keeps a BCD shadow of the typed digits for the 7-seg display.
//  On ENTER, presents the 14-bit operand to the downstream digit-separation stage
//    through a valid/ready handshake.
// PARAMETERS
//  MAX_DIGITS  4   max decimal digits accepted, legal range 1..4; 9999 < 2^14
//  VALUE_W     14  operand width; must hold 10^MAX_DIGITS-1
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset, asynchronous, active-low
//  key_valid    in   1        1-cycle strobe, key_code valid
//  key_code     in   5        0..9 = digit, 5'h10 ENTER, 5'h11 CLEAR, 5'h12 BACKSPACE; others invalid
//  out_ready    in   1        downstream ready to take the operand
//  value        out  VALUE_W  committed operand; stable while value_valid
//  value_valid  out  1        operand offered downstream
//  bcd          out  16       typed digits, nibble 0 = last typed, unused nibbles 0
//  ndig         out  3        number of digits held, 0..MAX_DIGITS
//  err          out  1        1-cycle pulse: key rejected
// BEHAVIOUR
//  Reset (async): state IDLE; acc, value, bcd, ndig = 0; value_valid = 0; err = 0.
//  States:
//   - IDLE: ndig == 0.
//   - ENTRY: 1 <= ndig <= MAX_DIGITS.
//   - HOLD: value_valid = 1.
//  Key effects are registered: a key sampled at edge t is visible at t+1 (latency 1).
//  Digit d in IDLE:
//   - d == 0: leading zero. Ignored, no err, stays in IDLE.
//   - d != 0: acc = d, bcd = d, ndig = 1, go to ENTRY.
//  Digit in ENTRY:
//   - ndig < MAX_DIGITS: acc = (acc<<3) + (acc<<1) + d, computed at VALUE_W bits;
//     bcd = {bcd[11:0], d}; ndig += 1.
//   - ndig == MAX_DIGITS: err pulse, no state change.
//  ENTER in IDLE or ENTRY:
//   - value = acc (0 when in IDLE), value_valid = 1, go to HOLD.
//  HOLD:
//   - value_valid and value stay stable until the edge with out_ready = 1.
//   - At that edge go to IDLE: value_valid = 0; acc, bcd, ndig cleared; value keeps its last operand.
//   - Every key in HOLD, including CLEAR, is dropped with an err pulse.
//   - A key arriving on the same edge as the handshake is also dropped with err.
//  CLEAR in IDLE or ENTRY: acc, bcd, ndig = 0; go to IDLE; no err.
//  Invalid key_code: err pulse, no other change.
//  out_ready is ignored outside HOLD.
//  Reset asserted mid-entry or mid-HOLD aborts immediately; the operand is lost and value_valid drops.
// CONFIGURATION
//  KB_NUM_ENTRY_BACKSPACE_EN defined:
//   - Adds a MAX_DIGITS-deep stack of prior acc values, pushed on each accepted digit.
//   - BACKSPACE in ENTRY pops the stack into acc; bcd = {4'h0, bcd[15:4]}; ndig -= 1.
//   - Reaching ndig == 0 returns to IDLE.
//   - BACKSPACE in IDLE: err pulse, no change.
//  KB_NUM_ENTRY_BACKSPACE_EN undefined:
//   - No stack is built.
//   - 5'h12 is an invalid code: err pulse, no change.
// TESTING
//  1. Keys 1,2,3,4 then ENTER, out_ready = 1 -> value = 1234 (14'h04D2), one-cycle valid;
//     then ndig = 0, bcd = 0.
//  2. Keys 0,0,7 then ENTER -> bcd = 16'h0007, ndig = 1, value = 7.
//  3. Keys 9,9,9,9,5 -> err on the 5th key, bcd = 16'h9999; ENTER -> value = 9999.
//  4. ENTER with out_ready = 0 for 5 cycles, then key 3 pulsed and out_ready = 1 on the same edge
//     -> value stable throughout, err = 1, the 3 is lost, state IDLE.
//  5. BACKSPACE_EN: keys 4,5,6, BACKSPACE, 1, ENTER -> value = 451; without the macro, BACKSPACE gives err.
//  6. Keys 8,8 then rst_n low mid-entry -> all outputs 0 asynchronously; ENTER after release -> value = 0.

Source files
------------

// File: rtl/kb_num_entry.sv
// kb_num_entry: operand-entry stage of the keyboard calculator.
// Collects decimal key presses into a binary operand plus a BCD shadow for
// the display, then offers the operand downstream with a valid/ready handshake.
// Optional feature: define KB_NUM_ENTRY_BACKSPACE_EN to enable BACKSPACE,
// which is backed by a stack of prior accumulator values.
module kb_num_entry #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [4:0]         key_code,
  input  logic               out_ready,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic [15:0]        bcd,
  output logic [2:0]         ndig,
  output logic               err
);

  localparam logic [4:0] KEY_ENTER = 5'h10;
  localparam logic [4:0] KEY_CLEAR = 5'h11;
`ifdef KB_NUM_ENTRY_BACKSPACE_EN
  localparam logic [4:0] KEY_BKSP  = 5'h12;
  localparam int         IDX_W     = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
`endif

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

  state_t             state;
  logic [VALUE_W-1:0] acc;

  logic               is_digit;
  logic [3:0]         digit;
  logic               ndig_full;
  logic [VALUE_W-1:0] acc_shift;

  assign is_digit  = (key_code <= 5'd9);
  assign digit     = key_code[3:0];
  assign ndig_full = (ndig >= 3'(MAX_DIGITS));
  // acc*10 + d, built from shifts and kept at operand width
  assign acc_shift = (acc << 3) + (acc << 1) + VALUE_W'(digit);

`ifdef KB_NUM_ENTRY_BACKSPACE_EN
  logic [VALUE_W-1:0] stack [MAX_DIGITS];
  logic               push;
  logic [VALUE_W-1:0] pop_val;

  // a digit is accepted when it starts an entry (non-zero in IDLE) or extends one
  assign push    = key_valid && is_digit &&
                   (((state == IDLE) && (digit != 4'd0)) ||
                    ((state == ENTRY) && !ndig_full));
  assign pop_val = stack[IDX_W'(ndig - 3'd1)];

  // save the accumulator as it was before each accepted digit
  always_ff @(posedge clk) begin
    if (push) stack[IDX_W'(ndig)] <= acc;
  end
`endif

  // entry FSM: all key effects and outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      bcd         <= '0;
      ndig        <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (key_valid) begin
            if (is_digit) begin
              if (state == IDLE) begin
                // leading zeros are swallowed silently
                if (digit != 4'd0) begin
                  acc   <= VALUE_W'(digit);
                  bcd   <= {12'h000, digit};
                  ndig  <= 3'd1;
                  state <= ENTRY;
                end
              end else if (ndig_full) begin
                err <= 1'b1;
              end else begin
                acc  <= acc_shift;
                bcd  <= {bcd[11:0], digit};
                ndig <= ndig + 3'd1;
              end
            end else if (key_code == KEY_ENTER) begin
              value       <= acc;
              value_valid <= 1'b1;
              state       <= HOLD;
            end else if (key_code == KEY_CLEAR) begin
              acc   <= '0;
              bcd   <= '0;
              ndig  <= '0;
              state <= IDLE;
`ifdef KB_NUM_ENTRY_BACKSPACE_EN
            end else if (key_code == KEY_BKSP) begin
              if (state == ENTRY) begin
                acc  <= pop_val;
                bcd  <= {4'h0, bcd[15:4]};
                ndig <= ndig - 3'd1;
                if (ndig == 3'd1) state <= IDLE;
              end else begin
                err <= 1'b1;
              end
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        HOLD: begin
          // keys are never accepted while an operand is on offer
          if (key_valid) err <= 1'b1;
          if (out_ready) begin
            value_valid <= 1'b0;
            acc         <= '0;
            bcd         <= '0;
            ndig        <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
